cam_frame_capture: RTL and testbench



---
 rtl/cam_pkg.sv | 28 ++
 rtl/cam_frame_capture_if.sv | 40 ++++
 rtl/rgb565_to_8b.sv | 46 ++++
 rtl/cam_frame_capture.sv | 161 ++++++++++++++++
 tb/tb_cam_frame_capture.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared types and constants for the camera frame-capture block.
//   cam_state_t            : capture FSM states
//   RGB_*_MSB / RGB_*_LSB  : bit positions of the RGB565 fields in a pixel word
//   CAM_DEFAULT_MAX_PIXELS : default frame-buffer capacity (160x120)
// -----------------------------------------------------------------------------
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_VS_HI = 3'd1,
    WAIT_VS_LO = 3'd2,
    CAPTURE    = 3'd3,
    DONE       = 3'd4
  } cam_state_t;

  // RGB565 word layout: {R5, G6, B5}
  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  localparam int CAM_DEFAULT_MAX_PIXELS = 19200;

endpackage

// File: rtl/cam_frame_capture_if.sv
// -----------------------------------------------------------------------------
// cam_frame_capture_if
// Bundles the camera input bus, the control handshake and the frame-buffer
// write port of cam_frame_capture.
//   start, vsync, href, pix_byte      : camera/control side, into the capture block
//   busy, done, overflow              : status out of the capture block
//   wr_en, wr_addr, wr_data           : frame-buffer write port
//   frame_pixels                      : pixel count of the last completed frame
// Handshake: there is no back-pressure. start is a one-cycle request that is
// accepted only while busy is low; each wr_en pulse is a complete RAM write
// that the frame buffer must accept in that cycle; done is a one-cycle pulse.
// Modports: slave = capture block, master = environment driving the camera.
// -----------------------------------------------------------------------------
interface cam_frame_capture_if #(
  parameter int ADDR_W = 15
);

  logic              start;
  logic              vsync;
  logic              href;
  logic [7:0]        pix_byte;
  logic              busy;
  logic              done;
  logic              overflow;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W:0]   frame_pixels;

  modport slave (
    input  start, vsync, href, pix_byte,
    output busy, done, overflow, wr_en, wr_addr, wr_data, frame_pixels
  );

  modport master (
    output start, vsync, href, pix_byte,
    input  busy, done, overflow, wr_en, wr_addr, wr_data, frame_pixels
  );

endinterface

// File: rtl/rgb565_to_8b.sv
// -----------------------------------------------------------------------------
// rgb565_to_8b
// Purely combinational reduction of an RGB565 pixel to one 8-bit value.
//   i_pix  [15:0] : RGB565 pixel {R5, G6, B5}
//   o_data [7:0]  : reduced pixel value
// Build option CAM_CAPTURE_GRAY_EN:
//   defined   : o_data = (r8 + 2*g8 + b8) >> 2, summed in 10 bits
//   undefined : o_data = red channel expanded to 8 bits {R5, R5[4:2]}
// Channels are widened to 8 bits by replicating their MSBs into the new LSBs,
// so full-scale inputs map to 0xFF.
// -----------------------------------------------------------------------------
module rgb565_to_8b
  import cam_pkg::*;
(
  input  logic [15:0] i_pix,
  output logic [7:0]  o_data
);

  logic [4:0] w_r5;
  logic [7:0] w_r8;

  assign w_r5 = i_pix[RGB_R_MSB:RGB_R_LSB];
  assign w_r8 = {w_r5, w_r5[4:2]};

`ifdef CAM_CAPTURE_GRAY_EN
  logic [5:0] w_g6;
  logic [4:0] w_b5;
  logic [7:0] w_g8;
  logic [7:0] w_b8;
  logic [9:0] w_sum;

  assign w_g6  = i_pix[RGB_G_MSB:RGB_G_LSB];
  assign w_b5  = i_pix[RGB_B_MSB:RGB_B_LSB];
  assign w_g8  = {w_g6, w_g6[5:4]};
  assign w_b8  = {w_b5, w_b5[4:2]};
  // Maximum sum is 255 + 510 + 255 = 1020, which fits in 10 bits.
  assign w_sum = {2'b00, w_r8} + {1'b0, w_g8, 1'b0} + {2'b00, w_b8};
  assign o_data = w_sum[9:2];
`else
  // Green and blue are not needed for the red-only output.
  logic w_unused_gb;
  assign w_unused_gb = ^{i_pix[RGB_G_MSB:RGB_G_LSB], i_pix[RGB_B_MSB:RGB_B_LSB]};
  assign o_data = w_r8;
`endif

endmodule

// File: rtl/cam_frame_capture.sv
// -----------------------------------------------------------------------------
// cam_frame_capture
// Camera capture stage feeding the frame-buffer RAM. After start it waits for a
// clean frame start (vsync high then low), pairs camera bytes into RGB565
// pixels, decimates by 2^DECIM_SHIFT in both axes, reduces each kept pixel to
// 8 bits and issues one RAM write per kept pixel. Writes stop at MAX_PIXELS
// (overflow flags the excess); the frame completes at the next vsync rise.
// Ports:
//   clk     : camera pixel clock, all logic on the rising edge
//   rst     : synchronous active-high reset
//   bus     : cam_frame_capture_if.slave (camera inputs, status, RAM write port)
//   o_state : current FSM state, for debug/observation
// Build option CAM_CAPTURE_GRAY_EN selects grayscale instead of red-only
// output; the selection lives in rgb565_to_8b.
// -----------------------------------------------------------------------------
module cam_frame_capture
  import cam_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int MAX_PIXELS  = CAM_DEFAULT_MAX_PIXELS,
  parameter int DECIM_SHIFT = 2,
  parameter int LINE_W      = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  cam_frame_capture_if.slave   bus,
  output cam_state_t           o_state
);

  localparam logic [LINE_W-1:0] DECIM_MASK = LINE_W'((1 << DECIM_SHIFT) - 1);
  localparam logic [ADDR_W:0]   MAX_CNT    = (ADDR_W + 1)'(MAX_PIXELS);

  cam_state_t        r_state;
  logic              r_href_d;
  logic              r_phase;      // 0: expecting high byte, 1: expecting low byte
  logic [7:0]        r_hi;
  logic [LINE_W-1:0] r_col;
  logic [LINE_W-1:0] r_line;
  logic [ADDR_W:0]   r_pix_cnt;
  logic              r_done;
  logic              r_overflow;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [ADDR_W:0]   r_frame_pixels;

  logic [15:0]       w_pix;
  logic [7:0]        w_conv;
  logic              w_keep;
  logic              w_line_end;
  logic              w_full;

  // The pixel is assembled from the latched high byte and the byte on the bus
  // now, so it converts in the same cycle the low byte arrives.
  assign w_pix      = {r_hi, bus.pix_byte};
  assign w_keep     = ((r_col & DECIM_MASK) == '0) && ((r_line & DECIM_MASK) == '0);
  assign w_line_end = r_href_d && !bus.href;
  assign w_full     = (r_pix_cnt == MAX_CNT);

  rgb565_to_8b u_conv (
    .i_pix  (w_pix),
    .o_data (w_conv)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_href_d       <= 1'b0;
      r_phase        <= 1'b0;
      r_hi           <= '0;
      r_col          <= '0;
      r_line         <= '0;
      r_pix_cnt      <= '0;
      r_done         <= 1'b0;
      r_overflow     <= 1'b0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_frame_pixels <= '0;
    end else begin
      r_wr_en  <= 1'b0;
      r_done   <= 1'b0;
      r_href_d <= bus.href;

      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state    <= WAIT_VS_HI;
            r_overflow <= 1'b0;
            r_pix_cnt  <= '0;
          end
        end

        WAIT_VS_HI: begin
          if (bus.vsync) r_state <= WAIT_VS_LO;
        end

        WAIT_VS_LO: begin
          if (!bus.vsync) begin
            r_state <= CAPTURE;
            r_line  <= '0;
            r_col   <= '0;
            r_phase <= 1'b0;
          end
        end

        CAPTURE: begin
          if (bus.vsync) begin
            // Frame ends at once; any half-received pixel is dropped.
            r_state        <= DONE;
            r_done         <= 1'b1;
            r_frame_pixels <= r_pix_cnt;
            r_phase        <= 1'b0;
          end else if (w_line_end) begin
            // A dangling high byte from an odd-length line is discarded here.
            r_phase <= 1'b0;
            r_col   <= '0;
            r_line  <= r_line + 1'b1;
          end else if (bus.href) begin
            if (!r_phase) begin
              r_hi    <= bus.pix_byte;
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              r_col   <= r_col + 1'b1;
              if (w_keep) begin
                if (w_full) begin
                  // Buffer full: flag it, keep the address where it is.
                  r_overflow <= 1'b1;
                end else begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= r_pix_cnt[ADDR_W-1:0];
                  r_wr_data <= w_conv;
                  r_pix_cnt <= r_pix_cnt + 1'b1;
                end
              end
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = (r_state != IDLE);
  assign bus.done         = r_done;
  assign bus.overflow     = r_overflow;
  assign bus.wr_en        = r_wr_en;
  assign bus.wr_addr      = r_wr_addr;
  assign bus.wr_data      = r_wr_data;
  assign bus.frame_pixels = r_frame_pixels;
  assign o_state          = r_state;

endmodule

// File: tb/tb_cam_frame_capture.sv
// -----------------------------------------------------------------------------
// tb_cam_frame_capture
// Two capture instances share one camera stimulus stream:
//   dut_a : DECIM_SHIFT=0, MAX_PIXELS=4 (no decimation, tiny buffer)
//   dut_b : DECIM_SHIFT=1, MAX_PIXELS=8 (2x decimation)
// Each frame is described as a list of lines of bytes; a frame-level reference
// model derives the expected writes, pixel count and overflow per instance.
// Honors CAM_CAPTURE_GRAY_EN for the expected pixel values.
// -----------------------------------------------------------------------------
module tb_cam_frame_capture;
  import cam_pkg::*;

  localparam int A_DS  = 0;
  localparam int A_MAX = 4;
  localparam int B_DS  = 1;
  localparam int B_MAX = 8;

  // ---------------- clock / reset ----------------
  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       start    = 1'b0;
  logic       vsync    = 1'b0;
  logic       href     = 1'b0;
  logic [7:0] pix_byte = 8'h00;

  always #5 clk = ~clk;

  cam_state_t state_a;
  cam_state_t state_b;

  cam_frame_capture_if #(.ADDR_W(15)) if_a ();
  cam_frame_capture_if #(.ADDR_W(15)) if_b ();

  assign if_a.start = start;  assign if_a.vsync = vsync;
  assign if_a.href  = href;   assign if_a.pix_byte = pix_byte;
  assign if_b.start = start;  assign if_b.vsync = vsync;
  assign if_b.href  = href;   assign if_b.pix_byte = pix_byte;

  cam_frame_capture #(.ADDR_W(15), .MAX_PIXELS(A_MAX), .DECIM_SHIFT(A_DS), .LINE_W(10)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave), .o_state(state_a)
  );
  cam_frame_capture #(.ADDR_W(15), .MAX_PIXELS(B_MAX), .DECIM_SHIFT(B_DS), .LINE_W(10)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave), .o_state(state_b)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int fails  = 0;

  logic [22:0] act_a[$];
  logic [22:0] act_b[$];
  logic [22:0] exp_q_a[$];
  logic [22:0] exp_q_b[$];
  logic [22:0] exp_tmp[$];
  logic [7:0]  frm_bytes[$];
  int          frm_len[$];
  int base_a, base_b, done0_a, done0_b;

  int   done_a = 0, done_b = 0, long_done_a = 0, long_done_b = 0;
  int   consec_a = 0, consec_b = 0;
  logic prev_wr_a = 1'b0, prev_wr_b = 1'b0, prev_dn_a = 1'b0, prev_dn_b = 1'b0;

  // Output monitor: collects writes and done pulses, notes back-to-back strobes.
  always @(negedge clk) begin
    if (if_a.wr_en === 1'b1) begin
      act_a.push_back({if_a.wr_addr, if_a.wr_data});
      if (prev_wr_a) consec_a <= consec_a + 1;
    end
    if (if_b.wr_en === 1'b1) begin
      act_b.push_back({if_b.wr_addr, if_b.wr_data});
      if (prev_wr_b) consec_b <= consec_b + 1;
    end
    if (if_a.done === 1'b1) begin
      done_a <= done_a + 1;
      if (prev_dn_a) long_done_a <= long_done_a + 1;
    end
    if (if_b.done === 1'b1) begin
      done_b <= done_b + 1;
      if (prev_dn_b) long_done_b <= long_done_b + 1;
    end
    prev_wr_a <= (if_a.wr_en === 1'b1);
    prev_wr_b <= (if_b.wr_en === 1'b1);
    prev_dn_a <= (if_a.done === 1'b1);
    prev_dn_b <= (if_b.done === 1'b1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] conv(input logic [15:0] p);
    int r, r8;
    r  = int'(p) / 2048;
    r8 = r * 8 + r / 4;
`ifdef CAM_CAPTURE_GRAY_EN
    begin
      int g, b, g8, b8;
      g  = (int'(p) / 32) % 64;
      b  = int'(p) % 32;
      g8 = g * 4 + g / 16;
      b8 = b * 8 + b / 4;
      return 8'((r8 + 2 * g8 + b8) / 4);
    end
`else
    return 8'(r8);
`endif
  endfunction

  // Walks the frame description: pixel k of line l is bytes 2k,2k+1; it is kept
  // when both k and l are multiples of the decimation step; writes stop at cap.
  task automatic model(input int ds, input int maxp, output int nw, output bit ovf);
    int pos;
    int step;
    step = 1 << ds;
    pos  = 0;
    nw   = 0;
    ovf  = 1'b0;
    exp_tmp.delete();
    for (int l = 0; l < frm_len.size(); l++) begin
      for (int k = 0; 2 * k + 1 < frm_len[l]; k++) begin
        if ((k % step) == 0 && (l % step) == 0) begin
          if (nw < maxp) begin
            exp_tmp.push_back({15'(nw), conv({frm_bytes[pos + 2 * k], frm_bytes[pos + 2 * k + 1]})});
            nw++;
          end else begin
            ovf = 1'b1;
          end
        end
      end
      pos += frm_len[l];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    base_a  = act_a.size();
    base_b  = act_b.size();
    done0_a = done_a;
    done0_b = done_b;
  endtask

  task automatic arm(input bit do_start);
    href = 1'b0;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    vsync = 1'b1;
    repeat (2) tick();
    vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic send_lines();
    int pos;
    pos = 0;
    for (int l = 0; l < frm_len.size(); l++) begin
      for (int k = 0; k < frm_len[l]; k++) begin
        href     = 1'b1;
        pix_byte = frm_bytes[pos + k];
        tick();
      end
      href     = 1'b0;
      pix_byte = 8'($urandom_range(0, 255));
      repeat ($urandom_range(1, 3)) tick();
      pos += frm_len[l];
    end
  endtask

  task automatic end_frame();
    href  = 1'b0;
    vsync = 1'b1;
    repeat (4) tick();
  endtask

  task automatic new_frame();
    frm_bytes.delete();
    frm_len.delete();
  endtask

  task automatic add_line(input int len, input bit rnd, input logic [7:0] b0, input logic [7:0] b1);
    frm_len.push_back(len);
    for (int k = 0; k < len; k++) begin
      if (rnd) frm_bytes.push_back(8'($urandom_range(0, 255)));
      else     frm_bytes.push_back((k % 2 == 0) ? b0 : b1);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic score_frame(input string name);
    int nw_a, nw_b;
    bit ovf_a, ovf_b;
    model(A_DS, A_MAX, nw_a, ovf_a);
    exp_q_a = exp_tmp;
    model(B_DS, B_MAX, nw_b, ovf_b);
    exp_q_b = exp_tmp;
    @(negedge clk);

    checks++;
    if (act_a.size() - base_a != nw_a) begin
      fails++; $display("FAIL %s a_write_count got %0d exp %0d", name, act_a.size() - base_a, nw_a);
    end
    for (int i = 0; i < nw_a && base_a + i < act_a.size(); i++) begin
      checks++;
      if (act_a[base_a + i] !== exp_q_a[i]) begin
        fails++; $display("FAIL %s a_write[%0d] got addr %0d data %h exp addr %0d data %h", name, i,
                          act_a[base_a + i][22:8], act_a[base_a + i][7:0], exp_q_a[i][22:8], exp_q_a[i][7:0]);
      end
    end
    checks++;
    if (if_a.frame_pixels !== 16'(nw_a)) begin
      fails++; $display("FAIL %s a_frame_pixels got %0d exp %0d", name, if_a.frame_pixels, nw_a);
    end
    checks++;
    if (if_a.overflow !== ovf_a) begin
      fails++; $display("FAIL %s a_overflow got %b exp %b", name, if_a.overflow, ovf_a);
    end
    checks++;
    if (done_a - done0_a != 1 || long_done_a != 0) begin
      fails++; $display("FAIL %s a_done pulses got %0d (long %0d) exp 1 (long 0)", name, done_a - done0_a, long_done_a);
    end
    checks++;
    if (consec_a != 0 || if_a.busy !== 1'b0) begin
      fails++; $display("FAIL %s a_idle back_to_back %0d busy %b exp 0/0", name, consec_a, if_a.busy);
    end

    checks++;
    if (act_b.size() - base_b != nw_b) begin
      fails++; $display("FAIL %s b_write_count got %0d exp %0d", name, act_b.size() - base_b, nw_b);
    end
    for (int i = 0; i < nw_b && base_b + i < act_b.size(); i++) begin
      checks++;
      if (act_b[base_b + i] !== exp_q_b[i]) begin
        fails++; $display("FAIL %s b_write[%0d] got addr %0d data %h exp addr %0d data %h", name, i,
                          act_b[base_b + i][22:8], act_b[base_b + i][7:0], exp_q_b[i][22:8], exp_q_b[i][7:0]);
      end
    end
    checks++;
    if (if_b.frame_pixels !== 16'(nw_b)) begin
      fails++; $display("FAIL %s b_frame_pixels got %0d exp %0d", name, if_b.frame_pixels, nw_b);
    end
    checks++;
    if (if_b.overflow !== ovf_b) begin
      fails++; $display("FAIL %s b_overflow got %b exp %b", name, if_b.overflow, ovf_b);
    end
    checks++;
    if (done_b - done0_b != 1 || long_done_b != 0) begin
      fails++; $display("FAIL %s b_done pulses got %0d (long %0d) exp 1 (long 0)", name, done_b - done0_b, long_done_b);
    end
    checks++;
    if (consec_b != 0 || if_b.busy !== 1'b0) begin
      fails++; $display("FAIL %s b_idle back_to_back %0d busy %b exp 0/0", name, consec_b, if_b.busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({if_a.busy, if_a.done, if_a.overflow, if_a.wr_en, if_a.wr_addr, if_a.wr_data, if_a.frame_pixels} !== '0
        || state_a !== IDLE) begin
      fails++; $display("FAIL reset_a outputs busy %b done %b ovf %b wr_en %b addr %0d data %h fp %0d state %0d exp all 0",
                        if_a.busy, if_a.done, if_a.overflow, if_a.wr_en, if_a.wr_addr, if_a.wr_data, if_a.frame_pixels, state_a);
    end
    checks++;
    if ({if_b.busy, if_b.done, if_b.overflow, if_b.wr_en, if_b.wr_addr, if_b.wr_data, if_b.frame_pixels} !== '0
        || state_b !== IDLE) begin
      fails++; $display("FAIL reset_b outputs busy %b done %b ovf %b wr_en %b addr %0d data %h fp %0d state %0d exp all 0",
                        if_b.busy, if_b.done, if_b.overflow, if_b.wr_en, if_b.wr_addr, if_b.wr_data, if_b.frame_pixels, state_b);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    logic [31:0] exp_data;
`ifdef CAM_CAPTURE_GRAY_EN
    exp_data = 32'h3F7F3FFF;
`else
    exp_data = 32'hFF0000FF;
`endif
    new_frame();
    frm_len.push_back(8);
    frm_bytes = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
    mark();
    arm(1'b1);
    send_lines();
    end_frame();
    score_frame("basic");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (act_a.size() <= base_a + i || act_a[base_a + i] !== {15'(i), exp_data[31 - 8 * i -: 8]}) begin
        fails++; $display("FAIL basic_const_a[%0d] got %h exp addr %0d data %h", i,
                          (act_a.size() > base_a + i) ? act_a[base_a + i] : 23'h0, i, exp_data[31 - 8 * i -: 8]);
      end
    end
  endtask

  task automatic test_decimation();
    new_frame();
    for (int l = 0; l < 4; l++) add_line(8, 1'b0, 8'hF8, 8'h00);
    mark();
    arm(1'b1);
    send_lines();
    end_frame();
    score_frame("decim");
    checks++;
    if (if_b.frame_pixels !== 16'd4 || act_b.size() - base_b != 4) begin
      fails++; $display("FAIL decim_b_count got fp %0d writes %0d exp 4/4", if_b.frame_pixels, act_b.size() - base_b);
    end
  endtask

  // Six kept pixels into dut_a (cap 4); start is pulsed mid-capture and must be ignored.
  task automatic test_overflow_and_busy_start();
    new_frame();
    add_line(12, 1'b0, 8'hFF, 8'hFF);
    mark();
    arm(1'b1);
    for (int k = 0; k < 12; k++) begin
      href     = 1'b1;
      pix_byte = 8'hFF;
      start    = (k == 10);
      tick();
      if (k == 7) begin
        @(negedge clk);
        checks++;
        if (if_a.overflow !== 1'b0) begin
          fails++; $display("FAIL ovf_at_cap got %b exp 0", if_a.overflow);
        end
      end
      if (k == 9) begin
        @(negedge clk);
        checks++;
        if (if_a.overflow !== 1'b1) begin
          fails++; $display("FAIL ovf_past_cap got %b exp 1", if_a.overflow);
        end
      end
    end
    start = 1'b0;
    href  = 1'b0;
    tick();
    end_frame();
    score_frame("overflow");
    checks++;
    if (if_a.wr_addr !== 15'd3) begin
      fails++; $display("FAIL ovf_addr_hold got %0d exp 3", if_a.wr_addr);
    end
  endtask

  task automatic test_odd_line();
    new_frame();
    frm_len   = '{3, 2};
    frm_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hFF, 8'hFF};
    mark();
    arm(1'b1);
    send_lines();
    end_frame();
    score_frame("odd_line");
    checks++;
    if (act_a.size() <= base_a + 1 || act_a[base_a + 1] !== {15'd1, 8'hFF}) begin
      fails++; $display("FAIL odd_next_line_pixel got %h exp addr 1 data ff",
                        (act_a.size() > base_a + 1) ? act_a[base_a + 1] : 23'h0);
    end
  endtask

  task automatic test_rst_mid_capture();
    int n_after;
    int d_after;
    new_frame();
    add_line(8, 1'b1, 8'h00, 8'h00);
    arm(1'b1);
    for (int k = 0; k < 5; k++) begin
      href     = 1'b1;
      pix_byte = frm_bytes[k];
      tick();
    end
    rst  = 1'b1;
    href = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (if_a.busy !== 1'b0 || if_a.wr_en !== 1'b0 || if_a.frame_pixels !== '0 || state_a !== IDLE ||
        if_b.busy !== 1'b0 || if_b.wr_en !== 1'b0 || if_b.frame_pixels !== '0 || state_b !== IDLE) begin
      fails++; $display("FAIL rst_abort got a busy %b wr %b fp %0d / b busy %b wr %b fp %0d exp all 0",
                        if_a.busy, if_a.wr_en, if_a.frame_pixels, if_b.busy, if_b.wr_en, if_b.frame_pixels);
    end
    rst     = 1'b0;
    d_after = done_a + done_b;
    vsync   = 1'b1;
    repeat (5) tick();
    checks++;
    if (done_a + done_b != d_after) begin
      fails++; $display("FAIL rst_no_done got %0d pulses exp 0", done_a + done_b - d_after);
    end
    // Re-arm with vsync low: camera activity must be ignored until vsync 1->0.
    vsync = 1'b0;
    tick();
    n_after = act_a.size() + act_b.size();
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      href     = 1'($urandom_range(0, 1));
      pix_byte = 8'($urandom_range(0, 255));
      tick();
    end
    href = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (state_a !== WAIT_VS_HI || state_b !== WAIT_VS_HI || act_a.size() + act_b.size() != n_after) begin
      fails++; $display("FAIL rearm_wait state a %0d b %0d writes %0d exp state %0d writes 0",
                        state_a, state_b, act_a.size() + act_b.size() - n_after, WAIT_VS_HI);
    end
    new_frame();
    add_line(8, 1'b1, 8'h00, 8'h00);
    add_line(6, 1'b1, 8'h00, 8'h00);
    mark();
    arm(1'b0);
    send_lines();
    end_frame();
    score_frame("rst_rearm");
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 10; f++) begin
      new_frame();
      repeat ($urandom_range(1, 5)) add_line($urandom_range(1, 12), 1'b1, 8'h00, 8'h00);
      mark();
      arm(1'b1);
      send_lines();
      end_frame();
      score_frame($sformatf("random%0d", f));
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic_frame();
    test_decimation();
    test_overflow_and_busy_start();
    test_odd_line();
    test_rst_mid_capture();
    test_random_frames();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
